// File: rtl/prbs_seq_ctrl.sv
// Sequencing controller for prbs_core_lfsr: paces lfsr_clk_enable at a programmable
// bit rate and runs fixed-length or continuous bursts with deferred PN-select changes.
module prbs_seq_ctrl #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             dac_clk,
    input  logic             reset_n,
    input  logic [4:0]       cfg_pn_select,
    input  logic [DIV_W-1:0] cfg_rate_div,
    input  logic [CNT_W-1:0] cfg_burst_len,
    input  logic             cfg_update,
    input  logic             start,
    input  logic             stop,
    input  logic             lfsr_data_valid,
    output logic             lfsr_clk_enable,
    output logic [4:0]       prbs_pn_select_reg,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [4:0] PN_MAX = 5'd14;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   act_div_q, act_div_d;
    logic [CNT_W-1:0]   act_len_q, act_len_d;
    logic [4:0]         pn_q, pn_d;
    logic [DIV_W-1:0]   sh_div_q, sh_div_d;
    logic [CNT_W-1:0]   sh_len_q, sh_len_d;
    logic [4:0]         sh_pn_q, sh_pn_d;
    logic               pend_q, pend_d;
    logic               en_q, en_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               upd_ok;
    logic               start_go;
    logic               burst_end;
    logic [CNT_W-1:0]   bit_cnt_inc;

    assign upd_ok      = cfg_update && (cfg_pn_select <= PN_MAX);
    assign start_go    = (state_q == IDLE) && start && !stop;
    // bit_cnt counts enables once their cycle has been issued to the core.
    assign bit_cnt_inc = bit_cnt_q + CNT_W'(en_q);
    assign burst_end   = (state_q == RUN) && en_q && (act_len_q != '0) &&
                         (bit_cnt_inc == act_len_q);

    always_ff @(posedge dac_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            act_div_q <= '0;
            act_len_q <= '0;
            pn_q      <= '0;
            sh_div_q  <= '0;
            sh_len_q  <= '0;
            sh_pn_q   <= '0;
            pend_q    <= 1'b0;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            act_div_q <= act_div_d;
            act_len_q <= act_len_d;
            pn_q      <= pn_d;
            sh_div_q  <= sh_div_d;
            sh_len_q  <= sh_len_d;
            sh_pn_q   <= sh_pn_d;
            pend_q    <= pend_d;
            en_q      <= en_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !stop) state_d = RUN;
            RUN:     if (stop || burst_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        act_div_d = act_div_q;
        act_len_d = act_len_q;
        pn_d      = pn_q;
        sh_div_d  = sh_div_q;
        sh_len_d  = sh_len_q;
        sh_pn_d   = sh_pn_q;
        pend_d    = pend_q;
        en_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = cfg_update && !upd_ok;

        if (state_q == IDLE) begin
            if (start_go && pend_q) begin
                act_div_d = sh_div_q;
                act_len_d = sh_len_q;
                pn_d      = sh_pn_q;
                pend_d    = 1'b0;
            end
            if (upd_ok) begin
                act_div_d = cfg_rate_div;
                act_len_d = cfg_burst_len;
                pn_d      = cfg_pn_select;
                pend_d    = 1'b0;
            end
            // The start edge is the first divider tick, so act_div=0 enables at once.
            if (start_go) begin
                bit_cnt_d = '0;
                if (act_div_d == '0) begin
                    en_d      = 1'b1;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = DIV_W'(1);
                end
            end
        end else begin
            if (lfsr_data_valid && pend_q) pn_d = sh_pn_q;
            if (upd_ok) begin
                sh_div_d = cfg_rate_div;
                sh_len_d = cfg_burst_len;
                sh_pn_d  = cfg_pn_select;
                pend_d   = 1'b1;
            end
            bit_cnt_d = bit_cnt_inc;
            if (stop) begin
                en_d = 1'b0;
            end else if (burst_end) begin
                done_d = 1'b1;
            end else if (div_cnt_q == act_div_q) begin
                en_d      = 1'b1;
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    assign lfsr_clk_enable    = en_q;
    assign prbs_pn_select_reg = pn_q;
    assign busy               = (state_q == RUN);
    assign done               = done_q;
    assign cfg_err            = err_q;
    assign bit_cnt            = bit_cnt_q;

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Bench for prbs_seq_ctrl: an edge-indexed arithmetic model of each run's enable schedule,
// checked every cycle, plus hand-computed literal expectations for each scenario.
module tb_prbs_seq_ctrl;

    localparam int DIV_W = 16;
    localparam int CNT_W = 32;
    localparam longint NEVER = 64'sh3fff_ffff_ffff_ffff;

    logic             dac_clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [4:0]       cfg_pn_select = '0;
    logic [DIV_W-1:0] cfg_rate_div = '0;
    logic [CNT_W-1:0] cfg_burst_len = '0;
    logic             cfg_update = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             lfsr_data_valid = 1'b0;
    logic             lfsr_clk_enable;
    logic [4:0]       prbs_pn_select_reg;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [CNT_W-1:0] bit_cnt;

    prbs_seq_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .dac_clk            (dac_clk),
        .reset_n            (reset_n),
        .cfg_pn_select      (cfg_pn_select),
        .cfg_rate_div       (cfg_rate_div),
        .cfg_burst_len      (cfg_burst_len),
        .cfg_update         (cfg_update),
        .start              (start),
        .stop               (stop),
        .lfsr_data_valid    (lfsr_data_valid),
        .lfsr_clk_enable    (lfsr_clk_enable),
        .prbs_pn_select_reg (prbs_pn_select_reg),
        .busy               (busy),
        .done               (done),
        .cfg_err            (cfg_err),
        .bit_cnt            (bit_cnt)
    );

    always #5 dac_clk = ~dac_clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on = 1'b0;
    int en_total = 0;
    int done_total = 0;
    int en_base;
    int done_base;
    int k;

    task automatic check_output(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: a run started at edge T with divider D issues enables registered at edges
    // T+D+k(D+1); a burst of L bits completes at edge T+L(D+1); a stop at edge S ends it.
    longint edge_no = 0;
    bit     m_started = 1'b0;
    longint m_T = 0, m_S = NEVER, m_C = NEVER, m_div = 0, m_len = 0;
    longint m_act_div = 0, m_act_len = 0, m_sh_div = 0, m_sh_len = 0;
    int     m_pn = 0, m_sh_pn = 0;
    bit     m_pend = 1'b0, m_err = 1'b0;
    bit     m_was_busy, m_go, m_upd_ok;

    function automatic bit m_busy(input longint e);
        return m_started && e >= m_T && e < m_S && (m_len == 0 || e < m_C);
    endfunction

    function automatic bit m_en(input longint e);
        return m_busy(e) && (e - m_T) >= m_div && ((e - m_T - m_div) % (m_div + 1)) == 0;
    endfunction

    function automatic longint m_bits(input longint e);
        longint m, n;
        if (!m_started) return 0;
        m = e;
        if (m_S < m) m = m_S;
        if (m_len != 0 && m_C < m) m = m_C;
        if (m - 1 >= m_T + m_div) n = (m - 1 - m_T - m_div) / (m_div + 1) + 1;
        else n = 0;
        return longint'(n[31:0]);
    endfunction

    function automatic bit m_done(input longint e);
        return m_started && m_len != 0 && e == m_C && m_S > m_C;
    endfunction

    always @(posedge dac_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_started = 1'b0;
            m_act_div = 0; m_act_len = 0;
            m_sh_div = 0; m_sh_len = 0; m_sh_pn = 0;
            m_pn = 0; m_pend = 1'b0; m_err = 1'b0;
        end else begin
            edge_no++;
            m_was_busy = m_busy(edge_no - 1);
            m_upd_ok = cfg_update && (cfg_pn_select <= 5'd14);
            m_err = cfg_update && (cfg_pn_select > 5'd14);
            if (m_was_busy) begin
                if (lfsr_data_valid && m_pend) m_pn = m_sh_pn;
                if (m_upd_ok) begin
                    m_sh_div = cfg_rate_div; m_sh_len = cfg_burst_len; m_sh_pn = cfg_pn_select;
                    m_pend = 1'b1;
                end
                if (stop) m_S = edge_no;
            end else begin
                m_go = start && !stop;
                if (m_go && m_pend) begin
                    m_act_div = m_sh_div; m_act_len = m_sh_len; m_pn = m_sh_pn; m_pend = 1'b0;
                end
                if (m_upd_ok) begin
                    m_act_div = cfg_rate_div; m_act_len = cfg_burst_len; m_pn = cfg_pn_select;
                    m_pend = 1'b0;
                end
                if (m_go) begin
                    m_started = 1'b1;
                    m_T = edge_no; m_S = NEVER;
                    m_div = m_act_div; m_len = m_act_len;
                    m_C = edge_no + m_len * (m_div + 1);
                end
            end
        end
    end

    always @(negedge dac_clk) begin
        if (chk_on && reset_n) begin
            check_output("enable", lfsr_clk_enable, m_en(edge_no));
            check_output("busy", busy, m_busy(edge_no));
            check_output("done", done, m_done(edge_no));
            check_output("cfg_err", cfg_err, m_err);
            check_output("bit_cnt", bit_cnt, m_bits(edge_no));
            check_output("pn_select", prbs_pn_select_reg, m_pn);
        end
    end

    always @(posedge dac_clk) begin
        if (lfsr_clk_enable === 1'b1) en_total++;
        if (done === 1'b1) done_total++;
    end

    task automatic apply_stimulus(input logic upd, input logic [4:0] pn, input logic [DIV_W-1:0] div,
                                  input logic [CNT_W-1:0] len, input logic st, input logic sp,
                                  input logic dv);
        cfg_update = upd;
        if (upd) begin
            cfg_pn_select = pn;
            cfg_rate_div  = div;
            cfg_burst_len = len;
        end
        start = st;
        stop = sp;
        lfsr_data_valid = dv;
        @(negedge dac_clk);
        cfg_update = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        lfsr_data_valid = 1'b0;
    endtask

    task automatic measure_first_enable(output int cycles);
        cycles = 0;
        while (lfsr_clk_enable !== 1'b1 && cycles < 40) begin
            @(negedge dac_clk);
            cycles++;
        end
    endtask

    initial begin
        #12;
        check_output("rst_enable", lfsr_clk_enable, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_bit_cnt", bit_cnt, 0);
        check_output("rst_pn", prbs_pn_select_reg, 0);
        check_output("rst_done", done, 0);
        #11 reset_n = 1'b1;
        @(negedge dac_clk);
        chk_on = 1'b1;

        // Burst of 31 bits at full rate.
        apply_stimulus(1'b1, 5'd1, 16'd0, 32'd31, 1'b0, 1'b0, 1'b0);
        en_base = en_total; done_base = done_total;
        apply_stimulus(1'b0, 5'd0, 16'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_output("t1_first_en", lfsr_clk_enable, 1);
        repeat (40) @(negedge dac_clk);
        check_output("t1_enables", en_total - en_base, 31);
        check_output("t1_dones", done_total - done_base, 1);
        check_output("t1_bit_cnt", bit_cnt, 31);
        check_output("t1_busy", busy, 0);
        check_output("t1_pn", prbs_pn_select_reg, 1);

        // Divided rate: div=3, four bits.
        apply_stimulus(1'b1, 5'd1, 16'd3, 32'd4, 1'b0, 1'b0, 1'b0);
        en_base = en_total; done_base = done_total;
        apply_stimulus(1'b0, 5'd0, 16'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        measure_first_enable(k);
        check_output("t2_first_en_delay", k, 3);
        repeat (25) @(negedge dac_clk);
        check_output("t2_enables", en_total - en_base, 4);
        check_output("t2_dones", done_total - done_base, 1);
        check_output("t2_bit_cnt", bit_cnt, 4);

        // Continuous at div=1, stopped after ten enables.
        apply_stimulus(1'b1, 5'd1, 16'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        en_base = en_total; done_base = done_total;
        apply_stimulus(1'b0, 5'd0, 16'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge dac_clk);
        apply_stimulus(1'b0, 5'd0, 16'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge dac_clk);
        check_output("t3_enables", en_total - en_base, 10);
        check_output("t3_bit_cnt", bit_cnt, 10);
        check_output("t3_dones", done_total - done_base, 0);
        check_output("t3_busy", busy, 0);
        en_base = en_total;
        apply_stimulus(1'b0, 5'd0, 16'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge dac_clk);
        check_output("t3_start_stop_busy", busy, 0);
        check_output("t3_start_stop_en", en_total - en_base, 0);

        // Deferred config while running.
        apply_stimulus(1'b1, 5'd1, 16'd2, 32'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 5'd0, 16'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge dac_clk);
        apply_stimulus(1'b1, 5'd3, 16'd5, 32'd2, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge dac_clk);
        check_output("t4_pn_held", prbs_pn_select_reg, 1);
        apply_stimulus(1'b0, 5'd0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        check_output("t4_pn_applied", prbs_pn_select_reg, 3);
        repeat (4) @(negedge dac_clk);
        apply_stimulus(1'b0, 5'd0, 16'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge dac_clk);
        en_base = en_total; done_base = done_total;
        apply_stimulus(1'b0, 5'd0, 16'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        measure_first_enable(k);
        check_output("t4_first_en_delay", k, 5);
        repeat (20) @(negedge dac_clk);
        check_output("t4_enables", en_total - en_base, 2);
        check_output("t4_dones", done_total - done_base, 1);

        // Rejected update leaves everything alone.
        apply_stimulus(1'b1, 5'd15, 16'd7, 32'd1, 1'b0, 1'b0, 1'b0);
        check_output("t5_err_pulse", cfg_err, 1);
        @(negedge dac_clk);
        check_output("t5_err_clear", cfg_err, 0);
        check_output("t5_pn", prbs_pn_select_reg, 3);
        en_base = en_total;
        apply_stimulus(1'b0, 5'd0, 16'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        measure_first_enable(k);
        check_output("t5_first_en_delay", k, 5);
        repeat (20) @(negedge dac_clk);
        check_output("t5_enables", en_total - en_base, 2);

        // Asynchronous reset mid-burst.
        apply_stimulus(1'b1, 5'd2, 16'd0, 32'd100, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 5'd0, 16'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge dac_clk);
        #2 reset_n = 1'b0;
        #1;
        check_output("t6_rst_enable", lfsr_clk_enable, 0);
        check_output("t6_rst_busy", busy, 0);
        check_output("t6_rst_bit_cnt", bit_cnt, 0);
        check_output("t6_rst_pn", prbs_pn_select_reg, 0);
        @(negedge dac_clk);
        #2 reset_n = 1'b1;
        @(negedge dac_clk);
        en_base = en_total;
        repeat (10) @(negedge dac_clk);
        check_output("t6_no_enable", en_total - en_base, 0);
        check_output("t6_idle", busy, 0);
        en_base = en_total;
        apply_stimulus(1'b0, 5'd0, 16'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge dac_clk);
        check_output("t6_resume", en_total - en_base, 3);
        apply_stimulus(1'b0, 5'd0, 16'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge dac_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
